// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative multiply / multiply-accumulate unit.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int                    REG_ADDR_W = 4;
    localparam logic [REG_ADDR_W-1:0] REG_PC     = 4'hF;

    // An UNROLL that does not divide WIDTH would leave multiplier bits unretired.
    function automatic bit unroll_legal(input int width, input int unroll);
        return (unroll > 0) && ((width % unroll) == 0);
    endfunction

endpackage

// File: rtl/mul_step.sv
// One combinational shift-add step: retires UNROLL multiplier bits per call.
module mul_step
    import mul_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic [WIDTH-1:0]  product,
    input  logic [WIDTH-1:0]  mcand,
    input  logic [UNROLL-1:0] slice,
    output logic [WIDTH-1:0]  product_nxt,
    output logic [WIDTH-1:0]  mcand_nxt
);

    // Add the multiplicand shifted into each set slice position; carries out of WIDTH are dropped.
    always_comb begin
        product_nxt = product;
        for (int i = 0; i < UNROLL; i++) begin
            if (slice[i]) begin
                product_nxt = product_nxt + (mcand << i);
            end
        end
        mcand_nxt = mcand << UNROLL;
    end

endmodule

// File: rtl/mul_unit.sv
// Iterative MUL / MLA unit sitting between the register file read ports and the write-back mux.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | retiring UNROLL multiplier bits per cycle, counter counts down
// DONE  | result registered; one-cycle write-back / flag strobes
module mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      op_a,
    input  logic [WIDTH-1:0]      op_b,
    input  logic [WIDTH-1:0]      op_acc,
    input  logic                  accumulate,
    input  logic                  set_flags,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  busy,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [WIDTH-1:0]      wb_data,
    output logic                  flags_we,
    output logic                  flag_n,
    output logic                  flag_z
);

    localparam int STEPS = WIDTH / UNROLL;
    localparam int CNT_W = $clog2(STEPS + 1);

    if (!unroll_legal(WIDTH, UNROLL)) begin : g_bad_unroll
        $error("mul_unit: UNROLL must divide WIDTH");
    end

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] prod_q;
    logic [WIDTH-1:0] acc_q;
    logic             accum_q;
    logic             setf_q;

    logic [WIDTH-1:0] prod_nxt;
    logic [WIDTH-1:0] mcand_nxt;
    logic [WIDTH-1:0] result;
    logic             last_step;

    mul_step #(
        .WIDTH  (WIDTH),
        .UNROLL (UNROLL)
    ) u_step (
        .product     (prod_q),
        .mcand       (mcand_q),
        .slice       (mplier_q[UNROLL-1:0]),
        .product_nxt (prod_nxt),
        .mcand_nxt   (mcand_nxt)
    );

    // Terminal count: the step taken while the counter reads 1 is the final one.
    assign last_step = (cnt_q == CNT_W'(1));
    assign result    = prod_nxt + (accum_q ? acc_q : '0);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode; write-back to PC is suppressed but flags still update.
    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        wb_we    = 1'b0;
        flags_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                wb_we    = (wb_addr != REG_PC);
                flags_we = setf_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, shift-add iteration and result/flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            acc_q    <= '0;
            accum_q  <= 1'b0;
            setf_q   <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            flag_n   <= 1'b0;
            flag_z   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q  <= op_a;
                        mplier_q <= op_b;
                        acc_q    <= op_acc;
                        accum_q  <= accumulate;
                        setf_q   <= set_flags;
                        wb_addr  <= rd_addr;
                        prod_q   <= '0;
                        cnt_q    <= CNT_W'(STEPS);
                    end
                end
                RUN: begin
                    prod_q   <= prod_nxt;
                    mcand_q  <= mcand_nxt;
                    mplier_q <= mplier_q >> UNROLL;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (last_step) begin
                        wb_data <= result;
                        flag_n  <= result[WIDTH-1];
                        flag_z  <= (result == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corner cases plus randomized MUL/MLA against a reference model.
module tb_mul_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        start4;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_acc;
    logic        accumulate;
    logic        set_flags;
    logic [3:0]  rd_addr;

    logic        busy,  wb_we,  flags_we,  flag_n,  flag_z;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy4, wb_we4, flags_we4, flag_n4, flag_z4;
    logic [3:0]  wb_addr4;
    logic [31:0] wb_data4;

    int n_chk;
    int n_err;

    mul_unit #(.WIDTH(32), .UNROLL(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_acc     (op_acc),
        .accumulate (accumulate),
        .set_flags  (set_flags),
        .rd_addr    (rd_addr),
        .busy       (busy),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flags_we   (flags_we),
        .flag_n     (flag_n),
        .flag_z     (flag_z)
    );

    mul_unit #(.WIDTH(32), .UNROLL(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_acc     (op_acc),
        .accumulate (accumulate),
        .set_flags  (set_flags),
        .rd_addr    (rd_addr),
        .busy       (busy4),
        .wb_we      (wb_we4),
        .wb_addr    (wb_addr4),
        .wb_data    (wb_data4),
        .flags_we   (flags_we4),
        .flag_n     (flag_n4),
        .flag_z     (flag_z4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: low 32 bits of a*b (+c), computed with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] c, input logic acc);
        logic [63:0] full;
        full = 64'(a) * 64'(b) + (acc ? 64'(c) : 64'd0);
        return full[31:0];
    endfunction

    // Launch one op on the UNROLL=1 unit from the current negedge and watch it to completion.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic acc, input logic sf, input logic [3:0] rd,
                         input bit inj, input string tag);
        logic [31:0] exp_d;
        logic [31:0] got_d;
        logic [3:0]  got_a;
        logic        gn, gz;
        int          cyc, busy_n, we_n, fwe_n, we_cyc, fwe_cyc;
        exp_d   = ref_result(a, b, c, acc);
        got_d   = '0;
        got_a   = '0;
        gn      = 1'b0;
        gz      = 1'b0;
        cyc     = 0;
        busy_n  = 0;
        we_n    = 0;
        fwe_n   = 0;
        we_cyc  = 0;
        fwe_cyc = 0;
        op_a       = a;
        op_b       = b;
        op_acc     = c;
        accumulate = acc;
        set_flags  = sf;
        rd_addr    = rd;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (busy && cyc < 100) begin
            cyc++;
            busy_n++;
            if (wb_we) begin
                we_n++;
                we_cyc = cyc;
                got_a  = wb_addr;
                got_d  = wb_data;
            end
            if (flags_we) begin
                fwe_n++;
                fwe_cyc = cyc;
                gn      = flag_n;
                gz      = flag_z;
            end
            if (inj && (cyc == 5 || cyc == 20)) begin
                start      = 1'b1;
                op_a       = 32'd99 + 32'(cyc);
                op_b       = 32'd77;
                op_acc     = 32'd1234;
                accumulate = ~acc;
                set_flags  = ~sf;
                rd_addr    = rd ^ 4'h1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_done"}, 64'(cyc < 100), 64'd1);
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
        chk({tag, "_we_pulses"}, 64'(we_n), (rd != 4'hF) ? 64'd1 : 64'd0);
        if (rd != 4'hF) begin
            chk({tag, "_we_latency"}, 64'(we_cyc), 64'd33);
            chk({tag, "_wb_addr"}, 64'(got_a), 64'(rd));
            chk({tag, "_wb_data"}, 64'(got_d), 64'(exp_d));
        end
        chk({tag, "_fwe_pulses"}, 64'(fwe_n), sf ? 64'd1 : 64'd0);
        if (sf) begin
            chk({tag, "_fwe_latency"}, 64'(fwe_cyc), 64'd33);
            chk({tag, "_flag_n"}, 64'(gn), 64'(exp_d[31]));
            chk({tag, "_flag_z"}, 64'(gz), 64'(exp_d == 32'd0));
        end
        chk({tag, "_wb_data_hold"}, 64'(wb_data), 64'(exp_d));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          cyc4, busy4_n, we4_n, fwe4_n, we_n, cyc;
        logic        gz4;
        logic [31:0] ra, rb, rc;
        n_chk      = 0;
        n_err      = 0;
        rst        = 1'b0;
        start      = 1'b0;
        start4     = 1'b0;
        op_a       = '0;
        op_b       = '0;
        op_acc     = '0;
        accumulate = 1'b0;
        set_flags  = 1'b0;
        rd_addr    = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy",     64'(busy),     64'd0);
        chk("rst_wb_we",    64'(wb_we),    64'd0);
        chk("rst_flags_we", 64'(flags_we), 64'd0);
        chk("rst_wb_addr",  64'(wb_addr),  64'd0);
        chk("rst_wb_data",  64'(wb_data),  64'd0);
        chk("rst_flag_nz",  64'({flag_n, flag_z}), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        do_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b0, 4'd3, 1'b0, "mul_7x6");
        do_op(32'hFFFF_FFFF, 32'd2, 32'd5, 1'b1, 1'b1, 4'd1, 1'b0, "mla_wrap");
        do_op(32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1, 4'd4, 1'b0, "mul_neg");
        do_op(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1, 4'd5, 1'b0, "mul_ovf");
        do_op(32'h1234_5678, 32'd9, 32'd11, 1'b1, 1'b1, 4'd6, 1'b1, "ignore_start");
        do_op(32'd2, 32'd2, 32'd0, 1'b0, 1'b1, 4'hF, 1'b0, "pc_dest");

        // Same PC-destination op on the UNROLL=4 unit.
        op_a       = 32'd2;
        op_b       = 32'd2;
        op_acc     = 32'd0;
        accumulate = 1'b0;
        set_flags  = 1'b1;
        rd_addr    = 4'hF;
        start4     = 1'b1;
        @(negedge clk);
        start4  = 1'b0;
        cyc4    = 0;
        busy4_n = 0;
        we4_n   = 0;
        fwe4_n  = 0;
        gz4     = 1'b1;
        while (busy4 && cyc4 < 40) begin
            cyc4++;
            busy4_n++;
            if (wb_we4) we4_n++;
            if (flags_we4) begin
                fwe4_n++;
                gz4 = flag_z4;
            end
            @(negedge clk);
        end
        chk("u4_busy_cycles", 64'(busy4_n), 64'd9);
        chk("u4_we_pulses",   64'(we4_n),   64'd0);
        chk("u4_fwe_pulses",  64'(fwe4_n),  64'd1);
        chk("u4_flag_z",      64'(gz4),     64'd0);
        chk("u4_wb_data",     64'(wb_data4), 64'd4);

        for (int i = 0; i < 24; i++) begin
            ra = pick_operand();
            rb = pick_operand();
            rc = pick_operand();
            do_op(ra, rb, rc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 1'b0, $sformatf("rnd%0d", i));
        end

        // Abort an operation with reset at cycle 10 of RUN.
        op_a       = 32'h0000_1234;
        op_b       = 32'h0000_5678;
        op_acc     = 32'd0;
        accumulate = 1'b0;
        set_flags  = 1'b1;
        rd_addr    = 4'd2;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_busy",     64'(busy),     64'd0);
        chk("abort_wb_we",    64'(wb_we),    64'd0);
        chk("abort_flags_we", 64'(flags_we), 64'd0);
        chk("abort_wb_addr",  64'(wb_addr),  64'd0);
        chk("abort_wb_data",  64'(wb_data),  64'd0);
        chk("abort_flag_nz",  64'({flag_n, flag_z}), 64'd0);
        we_n = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (wb_we || flags_we) we_n++;
            @(negedge clk);
        end
        chk("abort_no_strobe", 64'(we_n), 64'd0);
        do_op(32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 4'd7, 1'b0, "after_abort");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
